serial_deframer: RTL and testbench



---
 rtl/serial_pkg.sv | 15 +
 rtl/serial_deframer_if.sv | 21 ++
 rtl/serial_deframer_hold.sv | 48 ++++
 rtl/serial_deframer.sv | 119 +++++++++++
 tb/tb_serial_deframer.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/serial_pkg.sv
// Shared types and constants for the serial shift register / deframer pair.
package serial_pkg;

    typedef enum logic [0:0] {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_e;

    localparam logic DIR_MSB_FIRST = 1'b1;
    localparam logic DIR_LSB_FIRST = 1'b0;

    localparam int       DEFAULT_WIDTH     = 4;
    localparam logic [3:0] DEFAULT_SYNC_WORD = 4'b1010;

endpackage

// File: rtl/serial_deframer_if.sv
// Parallel word handshake between the deframer (master) and its sink (slave).
interface serial_deframer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             data_ready;
    logic             locked;
    logic             overrun;
    logic             clear_overrun;

    modport master (
        output data_out, data_valid, locked, overrun,
        input  data_ready, clear_overrun
    );

    modport slave (
        input  data_out, data_valid, locked, overrun,
        output data_ready, clear_overrun
    );
endinterface

// File: rtl/serial_deframer_hold.sv
// Output word register with valid/ready handshake and sticky overrun flag.
module serial_deframer_hold #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    input  logic             data_ready,
    input  logic             clear_overrun,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             overrun
);

    logic [WIDTH-1:0] data_r;
    logic             valid_r;
    logic             overrun_r;

    // Word register: a new word is dropped only when the slot is full and not being drained.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_r    <= {WIDTH{1'b0}};
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            if (load) begin
                if (!valid_r || data_ready) begin
                    data_r  <= word;
                    valid_r <= 1'b1;
                end
            end else if (valid_r && data_ready) begin
                valid_r <= 1'b0;
            end

            if (load && valid_r && !data_ready) begin
                overrun_r <= 1'b1;
            end else if (clear_overrun) begin
                overrun_r <= 1'b0;
            end
        end
    end

    assign data_out   = data_r;
    assign data_valid = valid_r;
    assign overrun    = overrun_r;

endmodule

// File: rtl/serial_deframer.sv
// Sync-word hunter and frame collector feeding a single-entry output word register.
module serial_deframer
    import serial_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] SYNC_WORD   = WIDTH'(DEFAULT_SYNC_WORD),
    parameter int               FRAME_WORDS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic serial_in,
    input  logic direction,
    serial_deframer_if.master bus
);

    localparam int         CW        = $clog2(WIDTH + 1);
    localparam logic [7:0] LAST_WORD = 8'(FRAME_WORDS - 1);

    state_e           state_r;
    logic [WIDTH-1:0] window_r;
    logic [WIDTH-1:0] shreg_r;
    logic [CW-1:0]    hunt_cnt_r;
    logic [CW-1:0]    bit_cnt_r;
    logic [7:0]       word_cnt_r;
    logic             dir_r;
    logic             locked_r;

    logic [WIDTH-1:0] window_nxt_s;
    logic [WIDTH-1:0] shreg_nxt_s;
    logic             dir_eff_s;
    logic             word_done_s;

    // Next window/shift values; the first bit of a word uses the live direction input.
    always_comb begin
        window_nxt_s = {window_r[WIDTH-2:0], serial_in};
        dir_eff_s    = (bit_cnt_r == CW'(0)) ? direction : dir_r;
        if (dir_eff_s == DIR_MSB_FIRST) begin
            shreg_nxt_s = {shreg_r[WIDTH-2:0], serial_in};
        end else begin
            shreg_nxt_s = {serial_in, shreg_r[WIDTH-1:1]};
        end
        if (enable && (state_r == COLLECT) && (bit_cnt_r == CW'(WIDTH - 1))) begin
            word_done_s = 1'b1;
        end else begin
            word_done_s = 1'b0;
        end
    end

    // Frame FSM: hunt for sync, then collect FRAME_WORDS words before hunting again.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= HUNT;
            window_r   <= {WIDTH{1'b0}};
            shreg_r    <= {WIDTH{1'b0}};
            hunt_cnt_r <= CW'(0);
            bit_cnt_r  <= CW'(0);
            word_cnt_r <= 8'd0;
            dir_r      <= DIR_MSB_FIRST;
            locked_r   <= 1'b0;
        end else if (enable) begin
            case (state_r)
                HUNT: begin
                    window_r <= window_nxt_s;
                    if (hunt_cnt_r != CW'(WIDTH)) begin
                        hunt_cnt_r <= hunt_cnt_r + CW'(1);
                    end
                    if ((window_nxt_s == SYNC_WORD) && (hunt_cnt_r >= CW'(WIDTH - 1))) begin
                        state_r    <= COLLECT;
                        locked_r   <= 1'b1;
                        bit_cnt_r  <= CW'(0);
                        word_cnt_r <= 8'd0;
                    end
                end
                COLLECT: begin
                    shreg_r <= shreg_nxt_s;
                    if (bit_cnt_r == CW'(0)) begin
                        dir_r <= direction;
                    end
                    if (word_done_s) begin
                        bit_cnt_r <= CW'(0);
                        if (word_cnt_r == LAST_WORD) begin
                            state_r    <= HUNT;
                            locked_r   <= 1'b0;
                            window_r   <= {WIDTH{1'b0}};
                            hunt_cnt_r <= CW'(0);
                            word_cnt_r <= 8'd0;
                        end else begin
                            word_cnt_r <= word_cnt_r + 8'd1;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r  <= HUNT;
                    locked_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.locked = locked_r;

    serial_deframer_hold #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk           (clk),
        .reset         (reset),
        .load          (word_done_s),
        .word          (shreg_nxt_s),
        .data_ready    (bus.data_ready),
        .clear_overrun (bus.clear_overrun),
        .data_out      (bus.data_out),
        .data_valid    (bus.data_valid),
        .overrun       (bus.overrun)
    );

endmodule

// File: tb/tb_serial_deframer.sv
// Randomised and directed checks of serial_deframer against a bit-list reference model.
module tb_serial_deframer;
    import serial_pkg::*;

    localparam int         W  = 4;
    localparam int         FW = 2;
    localparam logic [3:0] SW = 4'b1010;

    logic clk = 1'b0;
    logic reset, enable, serial_in, direction;

    serial_deframer_if #(.WIDTH(W)) bus ();

    serial_deframer #(.WIDTH(W), .SYNC_WORD(SW), .FRAME_WORDS(FW)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .serial_in (serial_in),
        .direction (direction),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Reference model state, expressed as bit lists rather than counters.
    bit   hist[$];
    bit   word_bits[$];
    bit   m_locked = 1'b0;
    bit   m_dir    = 1'b1;
    int   m_words  = 0;
    logic [W-1:0] exp_data = '0;
    bit   exp_valid = 1'b0;
    bit   exp_ovr   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit           done;
        logic [W-1:0] word;
        int           v;
        done = 1'b0;
        word = '0;
        if (reset) begin
            hist.delete();
            word_bits.delete();
            m_locked  = 1'b0;
            m_words   = 0;
            exp_data  = '0;
            exp_valid = 1'b0;
            exp_ovr   = 1'b0;
            return;
        end
        if (enable) begin
            if (!m_locked) begin
                hist.push_back(serial_in);
                if (hist.size() > W) void'(hist.pop_front());
                v = 0;
                foreach (hist[i]) v = v * 2 + int'(hist[i]);
                if (hist.size() == W && v == int'(SW)) begin
                    m_locked = 1'b1;
                    m_words  = 0;
                    word_bits.delete();
                    hist.delete();
                end
            end else begin
                if (word_bits.size() == 0) m_dir = direction;
                word_bits.push_back(serial_in);
                if (word_bits.size() == W) begin
                    for (int i = 0; i < W; i++) begin
                        if (m_dir) word[W-1-i] = word_bits[i];
                        else       word[i]     = word_bits[i];
                    end
                    done = 1'b1;
                    word_bits.delete();
                    m_words++;
                    if (m_words == FW) begin
                        m_locked = 1'b0;
                        hist.delete();
                    end
                end
            end
        end
        if (done && exp_valid && !bus.data_ready) exp_ovr = 1'b1;
        else if (bus.clear_overrun)               exp_ovr = 1'b0;
        if (done) begin
            if (!exp_valid || bus.data_ready) begin
                exp_data  = word;
                exp_valid = 1'b1;
            end
        end else if (exp_valid && bus.data_ready) begin
            exp_valid = 1'b0;
        end
    endtask

    task automatic step(input bit en, input bit sb, input bit dir, input bit rdy,
                        input bit clr, input bit rst);
        @(negedge clk);
        enable    = en;
        serial_in = sb;
        direction = dir;
        bus.data_ready    = rdy;
        bus.clear_overrun = clr;
        reset     = rst;
        @(posedge clk);
        model_update();
    endtask

    task automatic send(input logic [15:0] bits, input int n, input bit dir, input bit rdy);
        for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], dir, rdy, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("locked",     int'(bus.locked),     int'(m_locked));
            chk("data_valid", int'(bus.data_valid), int'(exp_valid));
            chk("overrun",    int'(bus.overrun),    int'(exp_ovr));
            if (exp_valid) chk("data_out", int'(bus.data_out), int'(exp_data));
        end
    end

    initial begin
        enable = 1'b0; serial_in = 1'b0; direction = 1'b1; reset = 1'b1;
        bus.data_ready = 1'b1; bus.clear_overrun = 1'b0;

        // Reset held two cycles with enable high and random serial data.
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'($urandom_range(1)), 1'b1, 1'b1, 1'b0, 1'b1);
            chk_en = 1'b1;
            #1;
            chk("rst_data",   int'(bus.data_out),   0);
            chk("rst_valid",  int'(bus.data_valid), 0);
            chk("rst_locked", int'(bus.locked),     0);
            chk("rst_ovr",    int'(bus.overrun),    0);
        end

        // MSB-first word.
        send(16'b11010, 5, 1'b1, 1'b1);
        #1 chk("msb_locked", int'(bus.locked), 1);
        send(16'b1100, 4, 1'b1, 1'b1);
        #1;
        chk("msb_valid", int'(bus.data_valid), 1);
        chk("msb_data",  int'(bus.data_out), 4'b1100);
        chk("msb_model", int'(exp_data), 4'b1100);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1 chk("msb_oneshot", int'(bus.data_valid), 0);

        // LSB-first frame of two words.
        do_reset();
        send(16'b110101100, 9, 1'b0, 1'b1);
        #1;
        chk("lsb_data",  int'(bus.data_out), 4'b0011);
        chk("lsb_model", int'(exp_data), 4'b0011);
        send(16'b0001, 4, 1'b0, 1'b1);
        #1;
        chk("lsb_data2",  int'(bus.data_out), 4'b1000);
        chk("lsb_unlock", int'(bus.locked), 0);

        // Stalled sink: second word dropped, overrun set then cleared.
        do_reset();
        send(16'b11010, 5, 1'b1, 1'b0);
        send(16'b10010111, 8, 1'b1, 1'b0);
        #1;
        chk("stall_data",  int'(bus.data_out), 4'b1001);
        chk("stall_ovr",   int'(bus.overrun), 1);
        chk("stall_model", int'(exp_ovr), 1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        #1 chk("ovr_clear", int'(bus.overrun), 0);

        // Enable gap inside a word.
        do_reset();
        send(16'b11010, 5, 1'b1, 1'b1);
        send(16'b10, 2, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom_range(1)), 1'b1, 1'b1, 1'b0, 1'b0);
        send(16'b11, 2, 1'b1, 1'b1);
        #1 chk("gap_data", int'(bus.data_out), 4'b1011);

        // Reset mid-word discards the partial word and drops lock.
        do_reset();
        send(16'b11010, 5, 1'b1, 1'b1);
        send(16'b10, 2, 1'b1, 1'b1);
        do_reset();
        #1;
        chk("midrst_locked", int'(bus.locked), 0);
        chk("midrst_valid",  int'(bus.data_valid), 0);
        send(16'b1100, 4, 1'b1, 1'b1);
        #1 chk("midrst_noword", int'(bus.data_valid), 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(9) < 7), 1'($urandom_range(1)), 1'($urandom_range(1)),
                 ($urandom_range(9) < 6), ($urandom_range(19) == 0), ($urandom_range(199) == 0));
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
